sim_ram_latency: RTL and testbench

Parametrised simulation data RAM with byte-lane write enables, a valid/ready request channel, and a valid/ready response channel with a configurable fixed response latency. It replaces the zero-latency combinational-read data memory in simulation top levels so that core load/store stall logic can be exercised. Storage is split into per-byte-lane banks. Out-of-range accesses are flagged instead of aliasing.

---
 rtl/sim_ram_latency_pkg.sv | 21 ++
 rtl/sim_ram_bank.sv | 23 ++
 rtl/sim_ram_latency.sv | 145 ++++++++++++++
 tb/tb_sim_ram_latency.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_ram_latency_pkg.sv
// Shared types and defaults for the latency-configurable simulation data RAM.
// The FSM state encoding is fixed so waveforms read the same across builds.
package sim_ram_latency_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DEPTH_LOG2 = 14;
    localparam int DEF_LATENCY    = 1;

    // The wait counter only ever holds values up to LATENCY-2.
    function automatic int cnt_width(input int latency);
        return (latency > 2) ? $clog2(latency - 1) : 1;
    endfunction

endpackage

// File: rtl/sim_ram_bank.sv
// One byte lane of the RAM: synchronous write, asynchronous read so a read
// word can be captured on the same edge that accepts the request.
module sim_ram_bank #(
    parameter int DEPTH_LOG2 = 14
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem_q [0:(1 << DEPTH_LOG2) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/sim_ram_latency.sv
// Byte-lane data RAM behind valid/ready request and response channels with a
// fixed response latency; one request outstanding, out-of-range flagged.
module sim_ram_latency
    import sim_ram_latency_pkg::*;
#(
    parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int    DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int    LATENCY    = DEF_LATENCY,
    parameter string INIT_FILE  = ""
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [DATA_WIDTH/8-1:0] req_write_en,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_write_data,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_read_data,
    output logic                    resp_error
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(LANES);
    localparam int CW    = cnt_width(LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = (LATENCY > 1) ? CW'(LATENCY - 2) : '0;

    if (LATENCY < 1 || (DATA_WIDTH % 8) != 0) begin : g_bad_params
        $fatal(1, "sim_ram_latency: LATENCY must be >= 1 and DATA_WIDTH a multiple of 8");
    end

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                  pend_err_q, pend_err_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;

    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  out_of_range;
    logic                  accept;
    logic                  is_read;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] capture_data;

    assign word_idx = req_addr[DEPTH_LOG2+OFF-1:OFF];

    if (ADDR_WIDTH > DEPTH_LOG2 + OFF) begin : g_range
        assign out_of_range = |req_addr[ADDR_WIDTH-1:DEPTH_LOG2+OFF];
    end else begin : g_no_range
        assign out_of_range = 1'b0;
    end

    // Sub-word byte offset bits do not select anything.
    if (OFF > 0) begin : g_low_bits
        logic unused_low_addr;
        assign unused_low_addr = ^req_addr[OFF-1:0];
    end

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign is_read = ~|req_write_en;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        sim_ram_bank #(
            .DEPTH_LOG2(DEPTH_LOG2)
        ) u_bank (
            .clk  (clk),
            .we   (accept && !out_of_range && req_write_en[gi]),
            .addr (word_idx),
            .wdata(req_write_data[8*gi +: 8]),
            .rdata(rd_word[8*gi +: 8])
        );
    end

    assign capture_data = (is_read && !out_of_range) ? rd_word : '0;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_data_d = pend_data_q;
        pend_err_d  = pend_err_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pend_data_d = capture_data;
                    pend_err_d  = out_of_range;
                    if (LATENCY > 1) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        // No wait stage: the captured word goes straight out.
                        state_d     = ST_RESP;
                        resp_data_d = capture_data;
                        resp_err_d  = out_of_range;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    resp_data_d = pend_data_q;
                    resp_err_d  = pend_err_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_data_q <= '0;
            pend_err_q  <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_data_q <= pend_data_d;
            pend_err_q  <= pend_err_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = (state_q == ST_RESP);
    assign resp_read_data = resp_data_q;
    assign resp_error     = resp_err_q;

endmodule

// File: tb/tb_sim_ram_latency.sv
// Scoreboard bench: a LATENCY=3 instance for functional/back-pressure/reset
// checks and a LATENCY=1 instance for back-to-back streaming.
module tb_sim_ram_latency;

    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_err;
    logic [3:0]  a_we;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_err;
    logic [3:0]  b_we;
    logic [31:0] b_addr, b_wdata, b_rdata;

    sim_ram_latency #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(14), .LATENCY(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write_en(a_we),
        .req_addr(a_addr), .req_write_data(a_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_read_data(a_rdata), .resp_error(a_err)
    );

    sim_ram_latency #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(14), .LATENCY(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write_en(b_we),
        .req_addr(b_addr), .req_write_data(b_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_read_data(b_rdata), .resp_error(b_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        time         due;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          bp_mode = 0;
    logic [31:0] a_last_data = '0;
    logic        a_last_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference memory: a word per index, bytes merged by enable mask.
    task automatic apply_model(input int which, input logic [3:0] we, input logic [31:0] addr,
                               input logic [31:0] wd, input int lat, output exp_t e);
        logic        oor;
        int          idx;
        logic [31:0] w;
        oor = |addr[31:16];
        idx = int'(addr[15:2]);
        e.err  = oor;
        e.due  = $time + lat * 10;
        e.data = '0;
        if (!oor) begin
            if (which == 0) w = mdl_a.exists(idx) ? mdl_a[idx] : 32'hxxxx_xxxx;
            else            w = mdl_b.exists(idx) ? mdl_b[idx] : 32'hxxxx_xxxx;
            if (we == 4'h0) begin
                e.data = w;
            end else begin
                for (int l = 0; l < 4; l++)
                    if (we[l]) w[8*l +: 8] = wd[8*l +: 8];
                if (which == 0) mdl_a[idx] = w;
                else            mdl_b[idx] = w;
            end
        end
    endtask

    task automatic req_a(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        logic rdy;
        bit   ok;
        ok = 0;
        @(negedge clk);
        a_req_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (n > 0) @(negedge clk);
            rdy = a_req_ready;
            @(posedge clk);
            ok = rdy;
        end
        if (ok) begin
            apply_model(0, we, addr, wd, LAT_A, e);
            qa.push_back(e);
        end else begin
            fail_now("a_accept_timeout");
        end
        #1 a_req_valid = 1'b0;
    endtask

    task automatic req_b(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd,
                         output time t_acc);
        exp_t e;
        logic rdy;
        bit   ok;
        ok = 0;
        t_acc = 0;
        @(negedge clk);
        b_req_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        for (int n = 0; n < 100 && !ok; n++) begin
            if (n > 0) @(negedge clk);
            rdy = b_req_ready;
            @(posedge clk);
            ok = rdy;
        end
        if (ok) begin
            t_acc = $time;
            apply_model(1, we, addr, wd, LAT_B, e);
            qb.push_back(e);
        end else begin
            fail_now("b_accept_timeout");
        end
        #1 b_req_valid = 1'b0;
    endtask

    task automatic drain_a();
        for (int n = 0; n < 200 && qa.size() > 0; n++) @(negedge clk);
        if (qa.size() > 0) fail_now("a_drain");
    endtask

    task automatic drain_b();
        for (int n = 0; n < 200 && qb.size() > 0; n++) @(negedge clk);
        if (qb.size() > 0) fail_now("b_drain");
    endtask

    // Response-ready driver for instance A, changed just after each edge.
    initial begin
        a_resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       a_resp_ready = 1'b1;
                1:       a_resp_ready = ($urandom_range(0, 3) != 0);
                default: a_resp_ready = 1'b0;
            endcase
        end
    end

    logic        pv_a = 1'b0, pr_a = 1'b0, pe_a = 1'b0;
    logic [31:0] pd_a = '0;

    initial begin : mon_a
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_resp_valid && !pv_a) begin
                if (qa.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL a_unexpected_resp: got data %h, expected no response (t=%0t)", a_rdata, $time);
                end else begin
                    chk("a_latency", 32'($time + 5), 32'(qa[0].due));
                end
            end
            if (pv_a && !pr_a) begin
                chk("a_hold_valid", 32'(a_resp_valid), 32'd1);
                chk("a_hold_data", a_rdata, pd_a);
                chk("a_hold_err", 32'(a_err), 32'(pe_a));
            end
            if (a_resp_valid) chk("a_req_ready_busy", 32'(a_req_ready), 32'd0);
            if (a_resp_valid && a_resp_ready && qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_resp_data", a_rdata, e.data);
                chk("a_resp_err", 32'(a_err), 32'(e.err));
                a_last_data = a_rdata;
                a_last_err  = a_err;
                $display("A resp: data=%h err=%0b exp=%h/%0b t=%0t", a_rdata, a_err, e.data, e.err, $time);
            end
            pv_a = a_resp_valid; pr_a = a_resp_ready; pd_a = a_rdata; pe_a = a_err;
        end
    end

    logic pv_b = 1'b0;

    initial begin : mon_b
        exp_t e;
        forever begin
            @(negedge clk);
            if (b_resp_valid && !pv_b) begin
                if (qb.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL b_unexpected_resp: got data %h, expected no response (t=%0t)", b_rdata, $time);
                end else begin
                    chk("b_latency", 32'($time + 5), 32'(qb[0].due));
                end
            end
            if (b_resp_valid && b_resp_ready && qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_resp_data", b_rdata, e.data);
                chk("b_resp_err", 32'(b_err), 32'(e.err));
                $display("B resp: data=%h err=%0b exp=%h/%0b t=%0t", b_rdata, b_err, e.data, e.err, $time);
            end
            pv_b = b_resp_valid;
        end
    end

    initial begin : stim
        logic [31:0] addr;
        logic [3:0]  we;
        time         t_acc, t_prev;
        int          bound;
        rst = 1'b1;
        a_req_valid = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
        b_req_valid = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
        b_resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("a_rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("a_rst_resp_valid", 32'(a_resp_valid), 32'd0);
        chk("a_rst_data", a_rdata, 32'd0);
        chk("a_rst_err", 32'(a_err), 32'd0);
        chk("b_rst_req_ready", 32'(b_req_ready), 32'd1);
        chk("b_rst_resp_valid", 32'(b_resp_valid), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 128; i++) req_a(4'hF, 32'(i * 4), $urandom);
        drain_a();

        // Full-word write then read back.
        req_a(4'hF, 32'h100, 32'hDEAD_BEEF);
        req_a(4'h0, 32'h100, 32'h0);
        drain_a();
        chk("a_full_word", a_last_data, 32'hDEAD_BEEF);

        // Partial lane write over the same word.
        req_a(4'b0101, 32'h100, 32'h1122_3344);
        req_a(4'h0, 32'h100, 32'h0);
        drain_a();
        chk("a_partial_lanes", a_last_data, 32'hDE22_BE44);

        // Response back-pressure with an ignored request pulse.
        bp_mode = 2;
        req_a(4'h0, 32'h100, 32'h0);
        bound = 0;
        while (!a_resp_valid && bound < 50) begin @(negedge clk); bound++; end
        if (!a_resp_valid) fail_now("a_bp_wait_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a_req_valid = 1'b1; a_we = 4'hF; a_addr = 32'h104; a_wdata = 32'h0BAD_0BAD;
        end
        @(negedge clk);
        a_req_valid = 1'b0;
        bp_mode = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("a_bp_release_valid", 32'(a_resp_valid), 32'd0);
        chk("a_bp_release_ready", 32'(a_req_ready), 32'd1);
        req_a(4'h0, 32'h104, 32'h0);
        drain_a();

        // Out-of-range read and write.
        req_a(4'h0, 32'h0001_0000, 32'h0);
        drain_a();
        chk("a_oor_err", 32'(a_last_err), 32'd1);
        chk("a_oor_data", a_last_data, 32'd0);
        req_a(4'hF, 32'h0001_0000, 32'hCAFE_F00D);
        req_a(4'h0, 32'h0, 32'h0);
        drain_a();
        chk("a_oor_no_alias_err", 32'(a_last_err), 32'd0);

        // Reset while waiting: the read must never answer.
        req_a(4'hF, 32'h108, 32'h5A5A_A5A5);
        drain_a();
        @(negedge clk);
        a_req_valid = 1'b1; a_we = 4'h0; a_addr = 32'h108;
        @(posedge clk);
        #1 a_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("a_rst_mid_valid", 32'(a_resp_valid), 32'd0);
        chk("a_rst_mid_ready", 32'(a_req_ready), 32'd1);
        repeat (6) @(negedge clk);
        req_a(4'h0, 32'h108, 32'h0);
        drain_a();
        chk("a_write_survives_rst", a_last_data, 32'h5A5A_A5A5);

        // Randomised traffic with random back-pressure.
        bp_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0)
                addr = $urandom | (32'h1 << $urandom_range(16, 31));
            else
                addr = 32'($urandom_range(0, 127) << 2) | 32'($urandom_range(0, 3));
            we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            req_a(we, addr, $urandom);
        end
        drain_a();
        bp_mode = 0;

        // LATENCY=1 streaming reads on instance B.
        for (int i = 0; i < 8; i++) req_b(4'hF, 32'(i * 4), $urandom, t_acc);
        drain_b();
        t_prev = 0;
        for (int i = 0; i < 8; i++) begin
            req_b(4'h0, 32'($urandom_range(0, 7) << 2), 32'h0, t_acc);
            if (i > 0) chk("b_accept_spacing", 32'(t_acc - t_prev), 32'd20);
            t_prev = t_acc;
        end
        drain_b();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
